id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage sitting directly upstream of the ALU and its control decoder.
- Registers decoded instruction fields and resolves data forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, inserts bubbles and applies branch flushes.
- Delivers final ALU operands (a, b), the 4-bit funct {funct7[5], funct3} and the 2-bit aluop consumed by the ALU control decoder.

Parameters:
- XLEN, 32, datapath width of operands, immediates and forwarded results.
- REGW, 5, register-index width.
- CNTW, 32, width of the stall/flush performance counters.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage presents a valid instruction.
- id_rs1_val, id_rs2_val  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  REGW  register indices.
- id_funct  in  4  {funct7[5], funct3}.
- id_aluop  in  2  0 = ld/st, 1 = branch, 2 = R-type, 3 = I-type.
- id_alusrc  in  1  1 selects the immediate for operand b.
- id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch  in  1 each  control bits.
- flush  in  1  taken branch/redirect; kills the instruction entering EX.
- exmem_regwrite  in  1; exmem_rd  in  REGW; exmem_result  in  XLEN  EX/MEM forwarding source.
- memwb_regwrite  in  1; memwb_rd  in  REGW; memwb_result  in  XLEN  MEM/WB forwarding source.
- stall  out  1  combinational; decode and fetch must hold their state this cycle.
- ex_valid  out  1  registered instruction in EX is real (not a bubble).
- alu_a, alu_b  out  XLEN  forwarded operands; alu_b already passed through the alusrc mux.
- ex_store_data  out  XLEN  forwarded rs2 value for stores.
- ex_funct  out  4; ex_aluop  out  2; ex_rd  out  REGW.
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch  out  1 each  gated by ex_valid.
- stall_count, flush_count  out  CNTW  saturating performance counters.

Behaviour:
- Reset (async, rst_n = 0): all registered fields cleared. ex_valid = 0, every ex_* control = 0, ex_rd = 0, ex_funct = 0, ex_aluop = 0, both counters = 0. Derived outputs: alu_a = 0, alu_b = 0, store_data = 0. Reset asserted mid-stream drops the in-flight instruction; no partial update.
- Latency: 1 cycle from id_* capture to ex_* outputs. Forwarding is combinational on the registered indices each cycle.
- Load-use hazard: stall = id_valid & ex_valid & ex_memread & (ex_rd != 0) & (ex_rd == id_rs1 | (ex_rd == id_rs2 & rule_uses_rs2)).
  - rule_uses_rs2 = (id_aluop == 2) | id_memwrite | id_branch.
- Clock-edge priority:
  - flush: load a bubble; stall is ignored.
  - else stall: load a bubble (ex_valid = 0, all controls 0). Decode holds, so the same instruction re-presents next cycle.
  - else: capture id_* with ex_valid = id_valid.
- Bubble: every control forced to 0. Data fields are don't-care but are cleared, for determinism.
- Forwarding, per source operand (rs1, rs2):
  - if EX/MEM regwrite, rd != 0 and rd matches: take exmem_result;
  - else if MEM/WB regwrite, rd != 0 and rd matches: take memwb_result;
  - else take the registered register-file value.
  - EX/MEM wins when both match. Register x0 is never forwarded and always yields the registered value.
- Operand assembly: alu_a = fwd_rs1; alu_b = alusrc ? imm : fwd_rs2; ex_store_data = fwd_rs2 regardless of alusrc.
- Counters:
  - stall_count increments on each cycle with stall = 1 and flush = 0.
  - flush_count increments on each cycle with flush = 1.
  - Both saturate at all-ones; no wrap.
- A simultaneous flush and stall counts as a flush only.

Decomposition:
- Shared package, pipe_pkg:
  - aluop constants ALUOP_LDST/BRANCH/RTYPE/ITYPE;
  - forward-select enum FWD_REG/FWD_EXMEM/FWD_MEMWB;
  - packed struct ctrl_t {regwrite, memread, memwrite, memtoreg, branch}.
- Sub-module: forward_unit, combinational. Given a source index and the two writeback ports it returns a forward-select; instantiated twice.

Test Plan:
- Reset then idle, id_valid = 0 → ex_valid = 0, all controls 0, counters 0, alu_a = alu_b = 0.
- add x3,x1,x2 with rs1_val = 5, rs2_val = 7, exmem (rd = 1, regwrite, result 100) and memwb (rd = 2, regwrite, result 200) → alu_a = 100, alu_b = 200, ex_aluop = 2, ex_funct = 0.
- Both forwarding ports target rd = 1 (exmem 0x11, memwb 0x22); separately rd = 0 with regwrite → alu_a = 0x11; for the rd = 0 case the registered value is used.
- lw x4 in EX, then decode presents add x5,x4,x1 → stall = 1 for exactly 1 cycle, bubble enters EX, stall_count = 1. The add is captured on the next edge.
- addi x6,x1,-3 (alusrc = 1, imm = 0xFFFFFFFD), same cycle as a load-use match on rs2 only → no stall (I-type ignores rs2); alu_b = 0xFFFFFFFD.
- Flush asserted together with a hazard → bubble loaded, flush_count = 1, stall_count unchanged. Preload stall_count = 0xFFFFFFFF and stall again → counter stays 0xFFFFFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline stage and its helpers.
//   - ALU operation class codes handed to the ALU control decoder
//   - forwarding-source select used by the forwarding units
//   - bundle of per-instruction control bits carried through EX
package pipe_pkg;

    // ALU operation class (id_aluop / ex_aluop)
    localparam logic [1:0] ALUOP_LDST   = 2'd0;
    localparam logic [1:0] ALUOP_BRANCH = 2'd1;
    localparam logic [1:0] ALUOP_RTYPE  = 2'd2;
    localparam logic [1:0] ALUOP_ITYPE  = 2'd3;

    // Where a source operand value comes from in EX
    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,   // value read from the register file in decode
        FWD_EXMEM = 2'd1,   // result sitting in EX/MEM
        FWD_MEMWB = 2'd2    // result sitting in MEM/WB
    } fwd_sel_e;

    // Control bits that travel with an instruction; all-zero is a bubble
    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of every non-clock signal around the ID/EX stage.
//   master : the surrounding pipeline (decode, EX/MEM, MEM/WB, redirect
//            logic) that drives id_*, flush and the forwarding sources, and
//            consumes stall and the ex_* outputs.
//   slave  : the ID/EX stage itself.
interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 32
);
    // decode side
    logic            id_valid;
    logic [XLEN-1:0] id_rs1_val;
    logic [XLEN-1:0] id_rs2_val;
    logic [XLEN-1:0] id_imm;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rd;
    logic [3:0]      id_funct;
    logic [1:0]      id_aluop;
    logic            id_alusrc;
    logic            id_regwrite;
    logic            id_memread;
    logic            id_memwrite;
    logic            id_memtoreg;
    logic            id_branch;
    logic            flush;

    // forwarding sources
    logic            exmem_regwrite;
    logic [REGW-1:0] exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_regwrite;
    logic [REGW-1:0] memwb_rd;
    logic [XLEN-1:0] memwb_result;

    // stage outputs
    logic            stall;
    logic            ex_valid;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] ex_store_data;
    logic [3:0]      ex_funct;
    logic [1:0]      ex_aluop;
    logic [REGW-1:0] ex_rd;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            ex_memwrite;
    logic            ex_memtoreg;
    logic            ex_branch;
    logic [CNTW-1:0] stall_count;
    logic [CNTW-1:0] flush_count;

    modport master (
        output id_valid, id_rs1_val, id_rs2_val, id_imm, id_rs1, id_rs2, id_rd,
               id_funct, id_aluop, id_alusrc, id_regwrite, id_memread,
               id_memwrite, id_memtoreg, id_branch, flush,
               exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result,
        input  stall, ex_valid, alu_a, alu_b, ex_store_data, ex_funct, ex_aluop,
               ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
               ex_branch, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1_val, id_rs2_val, id_imm, id_rs1, id_rs2, id_rd,
               id_funct, id_aluop, id_alusrc, id_regwrite, id_memread,
               id_memwrite, id_memtoreg, id_branch, flush,
               exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result,
        output stall, ex_valid, alu_a, alu_b, ex_store_data, ex_funct, ex_aluop,
               ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
               ex_branch, stall_count, flush_count
    );

endinterface

// File: rtl/forward_unit.sv
// Forwarding select for one source operand.
//   src_i                      : register index read by the instruction in EX
//   exmem_regwrite_i/exmem_rd_i: destination of the instruction in EX/MEM
//   memwb_regwrite_i/memwb_rd_i: destination of the instruction in MEM/WB
//   sel_o                      : which value the operand should use
// The younger EX/MEM result takes priority; x0 is never forwarded.
module forward_unit
    import pipe_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] src_i,
    input  logic            exmem_regwrite_i,
    input  logic [REGW-1:0] exmem_rd_i,
    input  logic            memwb_regwrite_i,
    input  logic [REGW-1:0] memwb_rd_i,
    output fwd_sel_e        sel_o
);

    always_comb begin
        // NOTE: assign a default before any branch so every path drives
        // sel_o and no latch is inferred.
        sel_o = FWD_REG;
        if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i)) begin
            sel_o = FWD_EXMEM;
        end else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i)) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding, load-use stall and flush.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : id_ex_stage_if.slave carrying decode inputs, flush,
//                EX/MEM and MEM/WB forwarding sources, the combinational
//                stall request, the registered ex_* fields, the forwarded
//                ALU operands and the saturating stall/flush counters.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int CNTW = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);

    // ---------------- EX-stage registers ----------------
    logic            valid_q,    valid_d;
    ctrl_t           ctrl_q,     ctrl_d;
    logic [REGW-1:0] rs1_q,      rs1_d;
    logic [REGW-1:0] rs2_q,      rs2_d;
    logic [REGW-1:0] rd_q,       rd_d;
    logic [XLEN-1:0] rs1_val_q,  rs1_val_d;
    logic [XLEN-1:0] rs2_val_q,  rs2_val_d;
    logic [XLEN-1:0] imm_q,      imm_d;
    logic [3:0]      funct_q,    funct_d;
    logic [1:0]      aluop_q,    aluop_d;
    logic            alusrc_q,   alusrc_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;

    // ---------------- load-use hazard ----------------
    // Only instructions that really read rs2 can hazard on it; I-type and
    // loads carry an unrelated value in that field.
    logic uses_rs2;
    logic stall;

    assign uses_rs2 = (bus.id_aluop == ALUOP_RTYPE) | bus.id_memwrite | bus.id_branch;
    assign stall    = bus.id_valid & valid_q & ctrl_q.memread & (rd_q != '0) &
                      ((rd_q == bus.id_rs1) | ((rd_q == bus.id_rs2) & uses_rs2));

    // ---------------- next state ----------------
    logic load;
    assign load = !bus.flush && !stall && bus.id_valid;

    always_comb begin
        // Bubble by default: controls off, data cleared for determinism.
        valid_d   = 1'b0;
        ctrl_d    = CTRL_NONE;
        rs1_d     = '0;
        rs2_d     = '0;
        rd_d      = '0;
        rs1_val_d = '0;
        rs2_val_d = '0;
        imm_d     = '0;
        funct_d   = '0;
        aluop_d   = '0;
        alusrc_d  = 1'b0;
        if (load) begin
            valid_d   = 1'b1;
            ctrl_d    = '{regwrite: bus.id_regwrite, memread: bus.id_memread,
                          memwrite: bus.id_memwrite, memtoreg: bus.id_memtoreg,
                          branch:   bus.id_branch};
            rs1_d     = bus.id_rs1;
            rs2_d     = bus.id_rs2;
            rd_d      = bus.id_rd;
            rs1_val_d = bus.id_rs1_val;
            rs2_val_d = bus.id_rs2_val;
            imm_d     = bus.id_imm;
            funct_d   = bus.id_funct;
            aluop_d   = bus.id_aluop;
            alusrc_d  = bus.id_alusrc;
        end

        // A flush outranks a stall, so a cycle with both counts as a flush.
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.flush) begin
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNTW'(1);
        end else if (stall) begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order. All state is
    // flops (no RAM), so everything is cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            ctrl_q      <= CTRL_NONE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            funct_q     <= '0;
            aluop_q     <= '0;
            alusrc_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
            imm_q       <= imm_d;
            funct_q     <= funct_d;
            aluop_q     <= aluop_d;
            alusrc_q    <= alusrc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ---------------- forwarding ----------------
    fwd_sel_e sel_a, sel_b;

    forward_unit #(.REGW(REGW)) u_fwd_rs1 (
        .src_i            (rs1_q),
        .exmem_regwrite_i (bus.exmem_regwrite),
        .exmem_rd_i       (bus.exmem_rd),
        .memwb_regwrite_i (bus.memwb_regwrite),
        .memwb_rd_i       (bus.memwb_rd),
        .sel_o            (sel_a)
    );

    forward_unit #(.REGW(REGW)) u_fwd_rs2 (
        .src_i            (rs2_q),
        .exmem_regwrite_i (bus.exmem_regwrite),
        .exmem_rd_i       (bus.exmem_rd),
        .memwb_regwrite_i (bus.memwb_regwrite),
        .memwb_rd_i       (bus.memwb_rd),
        .sel_o            (sel_b)
    );

    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    always_comb begin
        case (sel_a)
            FWD_EXMEM: fwd_rs1 = bus.exmem_result;
            FWD_MEMWB: fwd_rs1 = bus.memwb_result;
            default:   fwd_rs1 = rs1_val_q;
        endcase
        case (sel_b)
            FWD_EXMEM: fwd_rs2 = bus.exmem_result;
            FWD_MEMWB: fwd_rs2 = bus.memwb_result;
            default:   fwd_rs2 = rs2_val_q;
        endcase
    end

    // ---------------- outputs ----------------
    assign bus.stall         = stall;
    assign bus.ex_valid      = valid_q;
    assign bus.alu_a         = fwd_rs1;
    assign bus.alu_b         = alusrc_q ? imm_q : fwd_rs2;
    assign bus.ex_store_data = fwd_rs2;
    assign bus.ex_funct      = funct_q;
    assign bus.ex_aluop      = aluop_q;
    assign bus.ex_rd         = rd_q;
    assign bus.ex_regwrite   = ctrl_q.regwrite & valid_q;
    assign bus.ex_memread    = ctrl_q.memread  & valid_q;
    assign bus.ex_memwrite   = ctrl_q.memwrite & valid_q;
    assign bus.ex_memtoreg   = ctrl_q.memtoreg & valid_q;
    assign bus.ex_branch     = ctrl_q.branch   & valid_q;
    assign bus.stall_count   = stall_cnt_q;
    assign bus.flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. The counters are built 4 bits wide here so
// that saturation at all-ones (15) is reachable in a few dozen cycles.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int XLEN = 32;
    localparam int REGW = 5;
    localparam int CNTW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) bus ();

    id_ex_stage #(.XLEN(XLEN), .REGW(REGW), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_idle();
        bus.id_valid    = 1'b0;
        bus.id_rs1_val  = '0;
        bus.id_rs2_val  = '0;
        bus.id_imm      = '0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_rd       = '0;
        bus.id_funct    = '0;
        bus.id_aluop    = '0;
        bus.id_alusrc   = 1'b0;
        bus.id_regwrite = 1'b0;
        bus.id_memread  = 1'b0;
        bus.id_memwrite = 1'b0;
        bus.id_memtoreg = 1'b0;
        bus.id_branch   = 1'b0;
        bus.flush       = 1'b0;
    endtask

    task automatic fwd_off();
        bus.exmem_regwrite = 1'b0;
        bus.exmem_rd       = '0;
        bus.exmem_result   = '0;
        bus.memwb_regwrite = 1'b0;
        bus.memwb_rd       = '0;
        bus.memwb_result   = '0;
    endtask

    task automatic present_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] v1, input logic [31:0] v2);
        set_idle();
        bus.id_valid    = 1'b1;
        bus.id_rd       = rd;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rs1_val  = v1;
        bus.id_rs2_val  = v2;
        bus.id_aluop    = ALUOP_RTYPE;
        bus.id_regwrite = 1'b1;
    endtask

    task automatic present_lw(input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [31:0] v1, input logic [31:0] imm);
        set_idle();
        bus.id_valid    = 1'b1;
        bus.id_rd       = rd;
        bus.id_rs1      = rs1;
        bus.id_rs1_val  = v1;
        bus.id_imm      = imm;
        bus.id_aluop    = ALUOP_LDST;
        bus.id_alusrc   = 1'b1;
        bus.id_regwrite = 1'b1;
        bus.id_memread  = 1'b1;
        bus.id_memtoreg = 1'b1;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_n = 1'b0;
        set_idle();
        fwd_off();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        check("rst_alu_a",    bus.alu_a,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_ex_valid",    32'(bus.ex_valid),    32'd0);
        check("idle_regwrite",    32'(bus.ex_regwrite), 32'd0);
        check("idle_memread",     32'(bus.ex_memread),  32'd0);
        check("idle_memwrite",    32'(bus.ex_memwrite), 32'd0);
        check("idle_branch",      32'(bus.ex_branch),   32'd0);
        check("idle_alu_a",       bus.alu_a,            32'd0);
        check("idle_alu_b",       bus.alu_b,            32'd0);
        check("idle_store",       bus.ex_store_data,    32'd0);
        check("idle_stall_cnt",   32'(bus.stall_count), 32'd0);
        check("idle_flush_cnt",   32'(bus.flush_count), 32'd0);
        check("idle_stall",       32'(bus.stall),       32'd0);

        // ---------------- add x3,x1,x2 with forwarding ----------------
        present_add(5'd3, 5'd1, 5'd2, 32'd5, 32'd7);
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd1; bus.exmem_result = 32'd100;
        bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd2; bus.memwb_result = 32'd200;
        tick();
        set_idle();
        check("add_ex_valid", 32'(bus.ex_valid),    32'd1);
        check("add_alu_a",    bus.alu_a,            32'd100);
        check("add_alu_b",    bus.alu_b,            32'd200);
        check("add_store",    bus.ex_store_data,    32'd200);
        check("add_aluop",    32'(bus.ex_aluop),    32'd2);
        check("add_funct",    32'(bus.ex_funct),    32'd0);
        check("add_rd",       32'(bus.ex_rd),       32'd3);
        check("add_regwrite", 32'(bus.ex_regwrite), 32'd1);

        // both ports target x1: EX/MEM wins
        bus.exmem_rd = 5'd1; bus.exmem_result = 32'h11;
        bus.memwb_rd = 5'd1; bus.memwb_result = 32'h22;
        settle();
        check("prio_alu_a", bus.alu_a, 32'h11);
        check("prio_alu_b", bus.alu_b, 32'd7);
        bus.exmem_regwrite = 1'b0;
        settle();
        check("memwb_alu_a", bus.alu_a, 32'h22);

        // x0 source: forwarding from rd=0 must be ignored
        fwd_off();
        present_add(5'd7, 5'd0, 5'd2, 32'd9, 32'd7);
        tick();
        set_idle();
        bus.exmem_regwrite = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'h33;
        bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'h44;
        settle();
        check("x0_alu_a", bus.alu_a, 32'd9);

        // ---------------- load-use: lw x4 then add x5,x4,x1 ----------------
        fwd_off();
        present_lw(5'd4, 5'd1, 32'h1000, 32'd8);
        tick();
        check("lw_memread", 32'(bus.ex_memread), 32'd1);
        check("lw_alu_a",   bus.alu_a,           32'h1000);
        check("lw_alu_b",   bus.alu_b,           32'd8);
        present_add(5'd5, 5'd4, 5'd1, 32'h50, 32'h60);
        settle();
        check("lu_stall", 32'(bus.stall), 32'd1);
        tick();
        check("lu_bubble_valid", 32'(bus.ex_valid),    32'd0);
        check("lu_bubble_rw",    32'(bus.ex_regwrite), 32'd0);
        check("lu_stall_cnt",    32'(bus.stall_count), 32'd1);
        check("lu_stall_gone",   32'(bus.stall),       32'd0);
        tick();
        set_idle();
        bus.memwb_regwrite = 1'b1; bus.memwb_rd = 5'd4; bus.memwb_result = 32'hABC;
        settle();
        check("lu_add_valid", 32'(bus.ex_valid),    32'd1);
        check("lu_add_rd",    32'(bus.ex_rd),       32'd5);
        check("lu_add_alu_a", bus.alu_a,           32'hABC);
        check("lu_add_alu_b", bus.alu_b,           32'h60);
        check("lu_stall_cnt2", 32'(bus.stall_count), 32'd1);

        // ---------------- I-type ignores rs2 match ----------------
        fwd_off();
        present_lw(5'd4, 5'd1, 32'h2000, 32'd0);
        tick();
        present_add(5'd6, 5'd1, 5'd4, 32'h10, 32'h20);   // R-type on rs2 stalls
        settle();
        check("rtype_rs2_stall", 32'(bus.stall), 32'd1);
        set_idle();
        bus.id_valid    = 1'b1;
        bus.id_rd       = 5'd6;
        bus.id_rs1      = 5'd1;
        bus.id_rs2      = 5'd4;
        bus.id_rs1_val  = 32'h10;
        bus.id_imm      = 32'hFFFF_FFFD;
        bus.id_aluop    = ALUOP_ITYPE;
        bus.id_alusrc   = 1'b1;
        bus.id_regwrite = 1'b1;
        settle();
        check("addi_no_stall", 32'(bus.stall), 32'd0);
        tick();
        check("addi_valid",     32'(bus.ex_valid),    32'd1);
        check("addi_alu_a",     bus.alu_a,            32'h10);
        check("addi_alu_b",     bus.alu_b,            32'hFFFF_FFFD);
        check("addi_aluop",     32'(bus.ex_aluop),    32'd3);
        check("addi_stall_cnt", 32'(bus.stall_count), 32'd1);

        // ---------------- flush together with hazard ----------------
        present_lw(5'd4, 5'd1, 32'h3000, 32'd0);
        tick();
        present_add(5'd5, 5'd4, 5'd1, 32'h50, 32'h60);
        bus.flush = 1'b1;
        settle();
        check("fl_stall_req", 32'(bus.stall), 32'd1);
        tick();
        bus.flush = 1'b0;
        settle();
        check("fl_valid",     32'(bus.ex_valid),    32'd0);
        check("fl_flush_cnt", 32'(bus.flush_count), 32'd1);
        check("fl_stall_cnt", 32'(bus.stall_count), 32'd1);
        tick();
        check("fl_after_valid", 32'(bus.ex_valid), 32'd1);
        check("fl_after_rd",    32'(bus.ex_rd),    32'd5);

        // ---------------- stall counter saturation (4-bit) ----------------
        for (int i = 0; i < 14; i++) begin
            present_lw(5'd4, 5'd1, 32'h0, 32'd0);
            tick();
            present_add(5'd5, 5'd4, 5'd1, 32'h0, 32'h0);
            tick();
        end
        check("sat_reach", 32'(bus.stall_count), 32'd15);
        present_lw(5'd4, 5'd1, 32'h0, 32'd0);
        tick();
        present_add(5'd5, 5'd4, 5'd1, 32'h0, 32'h0);
        settle();
        check("sat_stall_req", 32'(bus.stall), 32'd1);
        tick();
        check("sat_hold", 32'(bus.stall_count), 32'd15);
        check("sat_flush_cnt", 32'(bus.flush_count), 32'd1);

        // ---------------- asynchronous reset mid-stream ----------------
        tick();   // the held add enters EX
        set_idle();
        check("pre_rst_valid", 32'(bus.ex_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",     32'(bus.ex_valid),    32'd0);
        check("arst_rd",        32'(bus.ex_rd),       32'd0);
        check("arst_stall_cnt", 32'(bus.stall_count), 32'd0);
        check("arst_flush_cnt", 32'(bus.flush_count), 32'd0);
        check("arst_alu_b",     bus.alu_b,            32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net: the directed sequence is short; never run away.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
